keyboard_overlay: RTL and testbench

Parametrised polyphonic successor to the single-key VGA keyboard pixel generator. It shades every currently pressed key of an N-octave on-screen piano, not just one key. Released keys keep a dimmer "release tail" colour for a programmable number of frames. It sits between the VGA timing counters / keyboard-image ROM and the RGB pins, and owns the ROM read address.

---
 rtl/keyboard_overlay_pkg.sv | 41 ++++
 rtl/keyboard_hold_timer.sv | 49 ++++
 rtl/keyboard_overlay.sv | 156 +++++++++++++++
 tb/tb_keyboard_overlay.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_overlay_pkg.sv
// rtl/keyboard_overlay_pkg.sv - piano geometry constants, pixel classes and note helpers
// Contents: OCT_W/WHITE_W/BLACK_W/BLACK_X0 geometry, BLACK_MASK,
//           pix_class_e, note_is_black(), white_to_note().
package keyboard_overlay_pkg;

  localparam int OCT_W    = 160;
  localparam int WHITE_W  = 23;
  localparam int BLACK_W  = 12;
  localparam int BLACK_X0 = 17;

  // Written with note 0 (C) as the MSB: bit (11 - note) is set for black notes.
  localparam logic [11:0] BLACK_MASK = 12'b0101_0010_1010;

  typedef enum logic [1:0] {
    CLS_BG    = 2'd0,  // above the keyboard region
    CLS_NONE  = 2'd1,  // in region but outside every octave
    CLS_BLACK = 2'd2,  // black-key body
    CLS_WHITE = 2'd3   // white key (including the strip below black keys)
  } pix_class_e;

  function automatic logic note_is_black(input logic [3:0] note);
    logic [3:0] idx;
    idx = 4'd11 - note;
    if (note > 4'd11) return 1'b0;
    return BLACK_MASK[idx];
  endfunction

  function automatic logic [3:0] white_to_note(input logic [2:0] w);
    case (w)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      3'd6:    return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/keyboard_hold_timer.sv
// rtl/keyboard_hold_timer.sv - per-key release-tail timers and per-frame key snapshots
// Ports: clk2, rst_n (sync, active-low), key_down[KEYS], frame_start
//        -> press_snap[KEYS], lit_snap[KEYS] (constant between frame starts)
module keyboard_hold_timer
  import keyboard_overlay_pkg::*;
#(
  parameter int KEYS        = 48,
  parameter int HOLD_FRAMES = 8
) (
  input  logic            clk2,
  input  logic            rst_n,
  input  logic [KEYS-1:0] key_down,
  input  logic            frame_start,
  output logic [KEYS-1:0] press_snap,
  output logic [KEYS-1:0] lit_snap
);

  localparam int TW = $clog2(HOLD_FRAMES + 1);

  logic [TW-1:0]   timer [KEYS];
  logic [KEYS-1:0] timer_nz;

  always_comb begin
    timer_nz = '0;
    for (int k = 0; k < KEYS; k++) timer_nz[k] = (timer[k] != '0);
  end

  // The snapshot reads the timer value from before this edge's update, so a
  // key released on the frame-start cycle is still lit from its last load.
  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      for (int k = 0; k < KEYS; k++) timer[k] <= '0;
      press_snap <= '0;
      lit_snap   <= '0;
    end else begin
      for (int k = 0; k < KEYS; k++) begin
        if (key_down[k])
          timer[k] <= TW'(HOLD_FRAMES);
        else if (frame_start && timer_nz[k])
          timer[k] <= timer[k] - TW'(1);
      end
      if (frame_start) begin
        press_snap <= key_down;
        lit_snap   <= key_down | timer_nz;
      end
    end
  end

endmodule

// File: rtl/keyboard_overlay.sv
// rtl/keyboard_overlay.sv - polyphonic on-screen piano key shading over a keyboard-image ROM
// Ports: clk2, rst_n (sync, active-low), key_down[12*OCTAVES], h_cnt/v_cnt[10],
//        vga_valid -> rom_addr[17] (combinational); rom_data[12] (one cycle
//        after rom_addr) -> RED/GREEN/BLUE[4] (registered, 2 cycles after h_cnt).
module keyboard_overlay
  import keyboard_overlay_pkg::*;
#(
  parameter int          OCTAVES     = 4,
  parameter int          KEY_Y0      = 384,
  parameter int          BLACK_Y1    = 439,
  parameter int          HOLD_FRAMES = 8,
  parameter logic [11:0] PRESS_RGB   = 12'h0F0,
  parameter logic [11:0] TAIL_RGB    = 12'h070,
  parameter logic [11:0] BG_RGB      = 12'h000,
  localparam int         KEYS        = 12 * OCTAVES
) (
  input  logic            clk2,
  input  logic            rst_n,
  input  logic [KEYS-1:0] key_down,
  input  logic [9:0]      h_cnt,
  input  logic [9:0]      v_cnt,
  input  logic            vga_valid,
  output logic [16:0]     rom_addr,
  input  logic [11:0]     rom_data,
  output logic [3:0]      RED,
  output logic [3:0]      GREEN,
  output logic [3:0]      BLUE
);

  localparam int KW = $clog2(KEYS);

  logic [KEYS-1:0] press_snap;
  logic [KEYS-1:0] lit_snap;
  logic            frame_start;

  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  keyboard_hold_timer #(
    .KEYS        (KEYS),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold_timer (
    .clk2        (clk2),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .frame_start (frame_start),
    .press_snap  (press_snap),
    .lit_snap    (lit_snap)
  );

  // Key locator: h_cnt -> octave, x within octave, black/white key, key index.
  logic [9:0]    x_abs;
  logic [9:0]    oct_base;
  logic [1:0]    oct;
  logic [7:0]    x_oct;
  logic [2:0]    white_w;
  logic          black_hit;
  logic [3:0]    black_note;
  logic          in_region;
  logic          in_keys;
  logic          over_black;
  logic [3:0]    note;
  logic [KW-1:0] key_idx;
  pix_class_e    cls;

  always_comb begin
    x_abs    = h_cnt - 10'd1;
    oct      = '0;
    oct_base = '0;
    for (int o = 1; o < OCTAVES; o++) begin
      if (x_abs >= 10'(o * OCT_W)) begin
        oct      = 2'(o);
        oct_base = 10'(o * OCT_W);
      end
    end
    x_oct = 8'(x_abs - oct_base);

    white_w = '0;
    for (int w = 1; w < 7; w++) begin
      if (x_oct >= 8'(w * WHITE_W)) white_w = 3'(w);
    end

    black_hit  = 1'b0;
    black_note = '0;
    for (int n = 0; n < 12; n++) begin
      if (note_is_black(4'(n)) &&
          x_oct >= 8'(BLACK_X0 + WHITE_W * (n / 2)) &&
          x_oct <  8'(BLACK_X0 + WHITE_W * (n / 2) + BLACK_W)) begin
        black_hit  = 1'b1;
        black_note = 4'(n);
      end
    end

    in_region  = v_cnt > 10'(KEY_Y0);
    in_keys    = (h_cnt != 10'd0) && (h_cnt <= 10'(OCT_W * OCTAVES));
    over_black = black_hit && (v_cnt <= 10'(BLACK_Y1));
    note       = over_black ? black_note : white_to_note(white_w);
    key_idx    = KW'(12 * int'(oct) + int'(note));

    if (!in_region)   cls = CLS_BG;
    else if (!in_keys) cls = CLS_NONE;
    else if (over_black) cls = CLS_BLACK;
    else              cls = CLS_WHITE;
  end

  assign rom_addr = in_region ?
                    17'(h_cnt) + 17'd640 * (17'(v_cnt) - 17'(KEY_Y0) - 17'd1) :
                    17'd0;

  // Stage 1: pixel attributes travel alongside the ROM read.
  logic [KW-1:0] s1_key;
  pix_class_e    s1_cls;
  logic          s1_valid;

  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      s1_key   <= '0;
      s1_cls   <= CLS_BG;
      s1_valid <= 1'b0;
    end else begin
      s1_key   <= key_idx;
      s1_cls   <= cls;
      s1_valid <= vga_valid;
    end
  end

  // Stage 2: colour decision against the frame snapshots.
  logic        s2_lit;
  logic [11:0] hi_rgb;
  logic [11:0] pix;
  logic [11:0] rgb_q;

  always_comb begin
    s2_lit = lit_snap[s1_key];
    hi_rgb = press_snap[s1_key] ? PRESS_RGB : TAIL_RGB;
    pix    = rom_data;
    case (s1_cls)
      CLS_BG:    pix = BG_RGB;
      CLS_NONE:  pix = rom_data;
      CLS_BLACK: pix = s2_lit ? hi_rgb : rom_data;
      // Zero ROM pixels are key outlines; leave them black even when lit.
      CLS_WHITE: pix = (s2_lit && rom_data != 12'h000) ? hi_rgb : rom_data;
      default:   pix = rom_data;
    endcase
    if (!s1_valid) pix = 12'h000;
  end

  always_ff @(posedge clk2) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= pix;
  end

  assign RED   = rgb_q[11:8];
  assign GREEN = rgb_q[7:4];
  assign BLUE  = rgb_q[3:0];

endmodule

// File: tb/tb_keyboard_overlay.sv
// tb/tb_keyboard_overlay.sv - directed scoreboard bench for keyboard_overlay
module tb_keyboard_overlay;

  localparam int KEYS = 48;

  logic            clk2 = 1'b0;
  logic            rst_n;
  logic [KEYS-1:0] key_down;
  logic [9:0]      h_cnt;
  logic [9:0]      v_cnt;
  logic            vga_valid;
  logic [16:0]     rom_addr;
  logic [11:0]     rom_data;
  logic [3:0]      RED;
  logic [3:0]      GREEN;
  logic [3:0]      BLUE;

  keyboard_overlay dut (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .key_down  (key_down),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .vga_valid (vga_valid),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  // ROM stand-in: the value chosen with each pixel arrives one cycle later.
  logic [11:0] rom_next = 12'h000;
  always @(posedge clk2) rom_data <= rom_next;

  typedef struct {
    int          due;
    bit          chk;
    logic [11:0] exp;
    logic [95:0] tag;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic            nxt_rst;
  logic [KEYS-1:0] nxt_keys;

  wire [11:0] rgb = {RED, GREEN, BLUE};

  always @(negedge clk2) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent_t e;
      e = sb.pop_front();
      if (e.chk) begin
        n_cmp++;
        assert (rgb === e.exp) else begin
          n_bad++;
          $error("FAIL %0s rgb=%h expected=%h", e.tag, rgb, e.exp);
        end
      end
    end
  end

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic val,
                      input logic [11:0] rom, input bit chk, input logic [11:0] exp,
                      input logic [95:0] tag);
    ent_t e;
    @(negedge clk2);
    rst_n     = nxt_rst;
    key_down  = nxt_keys;
    h_cnt     = h;
    v_cnt     = v;
    vga_valid = val;
    rom_next  = rom;
    e.due = cyc + 2;
    e.chk = chk;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic fstart();
    step(10'd0, 10'd0, 1'b0, 12'h000, 1'b1, 12'h000, "fstart");
  endtask

  task automatic check_addr(input logic [9:0] h, input logic [9:0] v, input logic [16:0] exp);
    @(negedge clk2);
    h_cnt     = h;
    v_cnt     = v;
    vga_valid = 1'b0;
    #1;
    n_cmp++;
    assert (rom_addr === exp) else begin
      n_bad++;
      $error("FAIL rom_addr h=%0d v=%0d got=%0d expected=%0d", h, v, rom_addr, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_down  = '0;
    h_cnt     = 10'd5;
    v_cnt     = 10'd450;
    vga_valid = 1'b1;
    nxt_rst   = 1'b0;
    nxt_keys  = '0;

    // Reset holds the output at zero even with valid, in-region pixels.
    repeat (3) step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h000, "rst_hold");
    nxt_rst = 1'b1;

    check_addr(10'd5,   10'd450, 17'd41605);
    check_addr(10'd10,  10'd385, 17'd10);
    check_addr(10'd300, 10'd384, 17'd0);
    check_addr(10'd641, 10'd524, 17'd89601);

    // No keys: ROM pass-through, background above, blank when not valid.
    fstart();
    step(10'd5,   10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "idle_w");
    step(10'd180, 10'd400, 1'b1, 12'hABC, 1'b1, 12'hABC, "idle_b");
    step(10'd300, 10'd100, 1'b1, 12'h777, 1'b1, 12'h000, "above");
    step(10'd5,   10'd450, 1'b0, 12'hFFF, 1'b1, 12'h000, "blank");
    step(10'd0,   10'd450, 1'b1, 12'h5A5, 1'b1, 12'h5A5, "h0");
    step(10'd641, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "h641");
    for (int i = 0; i < 16; i++)
      step(10'(1 + i * 40), 10'(385 + i * 8), 1'b1, 12'(i * 257 + 3), 1'b1,
           12'(i * 257 + 3), "sweep");

    // Key 0 pressed mid-frame: invisible until the next frame start.
    nxt_keys[0] = 1'b1;
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "pre_snap");
    fstart();
    step(10'd5,  10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "k0_w");
    step(10'd5,  10'd450, 1'b1, 12'h000, 1'b1, 12'h000, "k0_outline");
    step(10'd5,  10'd400, 1'b1, 12'h123, 1'b1, 12'h0F0, "k0_upper");
    step(10'd24, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "k2_off");

    // Key 13 (octave 1, C#): black body replaced regardless of ROM.
    nxt_keys[13] = 1'b1;
    fstart();
    step(10'd178, 10'd400, 1'b1, 12'h000, 1'b1, 12'h0F0, "k13_lo");
    step(10'd189, 10'd400, 1'b1, 12'h000, 1'b1, 12'h0F0, "k13_hi");
    step(10'd177, 10'd400, 1'b1, 12'hABC, 1'b1, 12'hABC, "k13_left");
    step(10'd190, 10'd400, 1'b1, 12'hABC, 1'b1, 12'hABC, "k13_right");
    step(10'd180, 10'd439, 1'b1, 12'h000, 1'b1, 12'h0F0, "k13_y1");
    step(10'd180, 10'd445, 1'b1, 12'h000, 1'b1, 12'h000, "k13_low0");
    step(10'd180, 10'd445, 1'b1, 12'h456, 1'b1, 12'h456, "k13_lowwr");
    step(10'd5,   10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "k0_still");

    // Release: 8 tail frames, then plain ROM.
    nxt_keys = '0;
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "rel_mid");
    for (int f = 1; f <= 8; f++) begin
      fstart();
      step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h070, "tail");
      step(10'd5, 10'd450, 1'b1, 12'h000, 1'b1, 12'h000, "tail_ol");
    end
    fstart();
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "tail_end");

    // Re-press during the tail.
    nxt_keys[0] = 1'b1;
    step(10'd5, 10'd300, 1'b1, 12'h000, 1'b1, 12'h000, "rearm");
    nxt_keys = '0;
    for (int f = 1; f <= 4; f++) begin
      fstart();
      step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h070, "tail_b");
    end
    nxt_keys[0] = 1'b1;
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h070, "press_mid");
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h070, "press_mid2");
    fstart();
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "repress");
    nxt_keys = '0;
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "rel_mid2");
    fstart();
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h070, "retail");

    // Chord across the whole keyboard.
    nxt_keys = '0;
    nxt_keys[0]  = 1'b1;
    nxt_keys[4]  = 1'b1;
    nxt_keys[47] = 1'b1;
    fstart();
    step(10'd5,   10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "ch_k0");
    step(10'd50,  10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "ch_k4");
    step(10'd631, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "ch_k47");
    step(10'd641, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "ch_h641");
    step(10'd50,  10'd400, 1'b1, 12'h321, 1'b1, 12'h321, "ch_k3off");

    // Reset mid-frame with keys held.
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h000, "pre_rst");
    nxt_rst = 1'b0;
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h000, "in_rst");
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h000, "in_rst2");
    nxt_rst = 1'b1;
    step(10'd5,   10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "post_rst");
    step(10'd631, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'hFFF, "post_rst47");
    fstart();
    step(10'd5, 10'd450, 1'b1, 12'hFFF, 1'b1, 12'h0F0, "after_fs");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk2);
    @(negedge clk2);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
